// File: rtl/apb4_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb4_master_pkg
// Brief    : Shared types and constants for the APB4 command master.
// Revision : 1.0 - initial release
// ============================================================================
package apb4_master_pkg;

    // Transfer phases of the command master
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb4_mst_state_e;

    // Normal, secure, data access
    localparam logic [2:0] APB4_PROT_DEFAULT = 3'b000;

endpackage : apb4_master_pkg
`default_nettype wire

// File: rtl/apb4_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : apb4_cmd_master
// Brief    : Single-outstanding valid/ready command to APB4 initiator with a
//            programmable per-command ACCESS timeout and a valid/ready
//            response channel.
// Revision : 1.0 - initial release
// ============================================================================
module apb4_cmd_master
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TMO_WIDTH  = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // command channel
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_write_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    input  logic [TMO_WIDTH-1:0]    cmd_tmo_i,
    // response channel
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_tmo_o,
    // APB4 requester
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [2:0]              pprot_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    input  logic [DATA_WIDTH-1:0]   prdata_i
);

    localparam logic [TMO_WIDTH-1:0] c_tmo_one = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

    apb4_mst_state_e         r_state;
    logic                    r_cmd_ready;
    logic                    r_rsp_valid;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic                    r_rsp_tmo;
    logic [ADDR_WIDTH-1:0]   r_paddr;
    logic                    r_psel;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [DATA_WIDTH-1:0]   r_pwdata;
    logic [DATA_WIDTH/8-1:0] r_pstrb;
    logic [TMO_WIDTH-1:0]    r_tmo;
    logic [TMO_WIDTH-1:0]    r_cnt;

    logic                    w_accept;
    logic                    w_tmo_hit;

    assign w_accept  = cmd_valid_i && r_cmd_ready;
    // The last allowed ACCESS cycle is the one where the count reaches tmo-1
    assign w_tmo_hit = (r_tmo != '0) && (r_cnt == (r_tmo - c_tmo_one));

    // Transfer FSM; every output is a register updated here
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tmo   <= 1'b0;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_pstrb     <= '0;
            r_tmo       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        r_psel      <= 1'b1;
                        r_penable   <= 1'b0;
                        r_paddr     <= cmd_addr_i;
                        r_pwrite    <= cmd_write_i;
                        // Reads never present write data or strobes on the bus
                        r_pwdata    <= cmd_write_i ? cmd_wdata_i : '0;
                        r_pstrb     <= cmd_write_i ? cmd_strb_i  : '0;
                        r_tmo       <= cmd_tmo_i;
                        r_state     <= SETUP;
                    end
                end

                SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ACCESS;
                end

                ACCESS: begin
                    if (pready_i) begin
                        // pready has priority over a timeout in the same cycle
                        r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
                        r_rsp_err   <= pslverr_i;
                        r_rsp_tmo   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_pwrite    <= 1'b0;
                        r_state     <= RESP;
                    end else if (w_tmo_hit) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_tmo   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_pwrite    <= 1'b0;
                        r_state     <= RESP;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + c_tmo_one;
                    end
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_tmo   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_tmo_o   = r_rsp_tmo;
    assign paddr_o     = r_paddr;
    assign pprot_o     = APB4_PROT_DEFAULT;
    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_pwrite;
    assign pwdata_o    = r_pwdata;
    assign pstrb_o     = r_pstrb;

endmodule : apb4_cmd_master
`default_nettype wire

// File: tb/tb_apb4_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_cmd_master
// Brief    : Directed table-driven bench for apb4_cmd_master with a simple
//            APB slave model (programmable wait states, error, read data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_cmd_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [7:0]  cmd_tmo;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_tmo;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int          n_vec  = 0;
    int          n_fail = 0;

    // slave model settings
    int          cur_wait   = 0;
    logic        cur_slverr = 1'b0;
    logic [31:0] cur_prdata = 32'h0;
    int          acc_cnt    = 0;

    apb4_cmd_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TMO_WIDTH  (8)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_addr_i  (cmd_addr),
        .cmd_write_i (cmd_write),
        .cmd_wdata_i (cmd_wdata),
        .cmd_strb_i  (cmd_strb),
        .cmd_tmo_i   (cmd_tmo),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .rsp_tmo_o   (rsp_tmo),
        .paddr_o     (paddr),
        .pprot_o     (pprot),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .pwdata_o    (pwdata),
        .pstrb_o     (pstrb),
        .pready_i    (pready),
        .pslverr_i   (pslverr),
        .prdata_i    (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count ACCESS cycles so the slave can answer after cur_wait wait states
    always @(posedge clk) begin
        if (psel && penable) acc_cnt <= acc_cnt + 1;
        else                 acc_cnt <= 0;
    end

    // Outside the completing cycle, pslverr and prdata carry junk that must be ignored
    assign pready  = psel && penable && (acc_cnt == cur_wait);
    assign pslverr = pready ? cur_slverr : (psel && penable);
    assign prdata  = pready ? cur_prdata : 32'hBAD0_BAD0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [7:0]  tmo;
        int          wait_n;
        logic        slverr;
        logic [31:0] prdata;
        int          exp_lat;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic all_outs_zero();
        return ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_tmo, paddr, pprot,
                 psel, penable, pwrite, pwdata, pstrb} == '0);
    endfunction

    // Sample at negedge until cmd_ready is seen; acceptance is at the next posedge
    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        bit ok;
        int cyc, setup_n, acc_n, bus_bad;
        cur_wait   = v.wait_n;
        cur_slverr = v.slverr;
        cur_prdata = v.prdata;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_write = v.wr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        cmd_tmo   = v.tmo;
        rsp_ready = 1'b1;
        wait_ready(ok);
        check($sformatf("v%0d_accept", idx), {31'b0, ok}, 32'd1);
        @(negedge clk);
        // Scramble the command inputs to prove the fields were latched
        cmd_valid = 1'b0;
        cmd_addr  = 32'hFFFF_FFF0;
        cmd_write = ~v.wr;
        cmd_wdata = 32'h0F0F_0F0F;
        cmd_strb  = 4'hA;
        cmd_tmo   = 8'd1;
        cyc = 1; setup_n = 0; acc_n = 0; bus_bad = 0;
        while (!rsp_valid && cyc < 60) begin
            if (psel) begin
                if (penable) acc_n++;
                else         setup_n++;
                if (paddr !== v.addr || pwrite !== v.wr || pprot !== 3'b000 ||
                    pwdata !== (v.wr ? v.wdata : 32'h0) ||
                    pstrb  !== (v.wr ? v.strb  : 4'h0))
                    bus_bad++;
            end
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d_latency", idx), cyc, v.exp_lat);
        check($sformatf("v%0d_access_cycles", idx), acc_n, v.exp_acc);
        check($sformatf("v%0d_setup_cycles", idx), setup_n, 32'd1);
        check($sformatf("v%0d_bus_fields_bad", idx), bus_bad, 32'd0);
        check($sformatf("v%0d_rdata", idx), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), {31'b0, rsp_err}, {31'b0, v.exp_err});
        check($sformatf("v%0d_tmo", idx), {31'b0, rsp_tmo}, {31'b0, v.exp_tmo});
        @(negedge clk);
        // {rsp_valid, cmd_ready, psel, penable, pwrite} after the handshake
        check($sformatf("v%0d_post_idle", idx),
              {27'b0, rsp_valid, cmd_ready, psel, penable, pwrite}, 32'b01000);
    endtask

    initial begin
        bit ok;
        int bad;

        //          wr    addr          wdata          strb  tmo  wait slverr prdata        lat acc rdata          err   tmo
        vecs[0] = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 8'd0, 0,   1'b0, 32'h0,        3, 1, 32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_000C, 32'h1111_1111, 4'hF, 8'd0, 5,   1'b0, 32'h1234_5678, 8, 6, 32'h1234_5678, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 8'd0, 0,   1'b1, 32'h0000_00AA, 3, 1, 32'h0000_00AA, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0014, 32'h0,        4'h0, 8'd4, 255, 1'b0, 32'h5555_5555, 6, 4, 32'h0,        1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_0018, 32'h0,        4'h0, 8'd4, 3,   1'b0, 32'h0000_5A5A, 6, 4, 32'h0000_5A5A, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_001C, 32'hA5A5_0001, 4'h5, 8'd1, 255, 1'b0, 32'h0,        3, 1, 32'h0,        1'b1, 1'b1};
        vecs[6] = '{1'b1, 32'h0000_0100, 32'h0BAD_CAFE, 4'h3, 8'd0, 2,   1'b1, 32'h7777_7777, 5, 3, 32'h0,        1'b1, 1'b0};
        vecs[7] = '{1'b0, 32'h0000_0104, 32'h0,        4'h0, 8'd3, 2,   1'b0, 32'h0000_0077, 5, 3, 32'h0000_0077, 1'b0, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
        cmd_wdata = '0; cmd_strb = '0; cmd_tmo = '0; rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", {31'b0, all_outs_zero()}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("first_cycle_ready", {31'b0, cmd_ready}, 32'd1);

        // Table-driven transfers
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Response backpressure with a second command waiting
        cur_wait = 0; cur_slverr = 1'b0; cur_prdata = 32'hCAFE_F00D;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 32'h20; cmd_write = 1'b0; cmd_tmo = 8'd0;
        rsp_ready = 1'b0;
        wait_ready(ok);
        check("bp_accept", {31'b0, ok}, 32'd1);
        @(negedge clk);
        cmd_addr = 32'h24; cmd_write = 1'b1; cmd_wdata = 32'h0000_0042; cmd_strb = 4'h1;
        wait_rsp(ok);
        check("bp_rsp_seen", {31'b0, ok}, 32'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_rdata !== 32'hCAFE_F00D || rsp_err || rsp_tmo ||
                cmd_ready || psel)
                bad++;
            @(negedge clk);
        end
        check("bp_hold_bad_cycles", bad, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        // {rsp_valid, cmd_ready, psel}: response gone, second not yet accepted
        check("bp_after_handshake", {29'b0, rsp_valid, cmd_ready, psel}, 32'b010);
        @(negedge clk);
        check("bp_second_setup", {30'b0, psel, penable}, 32'b10);
        check("bp_second_addr", paddr, 32'h24);
        cmd_valid = 1'b0;
        wait_rsp(ok);
        check("bp_second_rsp", {31'b0, ok}, 32'd1);
        check("bp_second_rdata", rsp_rdata, 32'h0);
        @(negedge clk);

        // Reset pulse in the middle of ACCESS
        cur_wait = 1000;
        cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_write = 1'b0; cmd_tmo = 8'd0;
        wait_ready(ok);
        check("rst_accept", {31'b0, ok}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (penable) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst_reached_access", {31'b0, ok}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs_zero", {31'b0, all_outs_zero()}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_recover", {29'b0, cmd_ready, rsp_valid, psel}, 32'b100);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid || psel) bad++;
            @(negedge clk);
        end
        check("rst_mid_no_rsp", bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_apb4_cmd_master
`default_nettype wire
